pwm_duty_decoder: RTL and testbench

PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

---
 rtl/pwm_duty_decoder.sv | 242 ++++++++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers the dim level of a PWM light-control waveform.
// Measures high time and rising-to-rising period of pwm_in in clk cycles,
// reports duty (saturated to 255) with a one-cycle duty_valid pulse, and
// reports stuck-high / stuck-low inputs after TIMEOUT cycles without an edge.
// duty_valid rises on the third clk edge, counting the edge that first
// samples the high level closing a period (two sync flops + output register).
//
// Optional feature: define PWM_DEC_GLITCH_FILTER_EN to require 3 consecutive
// equal synchronized samples before s changes (latency becomes 5 edges).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (release synchronized)
//   pwm_in     in   PWM waveform, asynchronous to clk
//   duty       out  [7:0] high time in cycles, saturated to 255
//   duty_valid out  one-cycle pulse when duty/period_err/light_on update
//   light_on   out  last decoded duty is non-zero
//   period_err out  measured period differs from PERIOD by more than 1
module pwm_duty_decoder #(
    parameter int unsigned PERIOD  = 256,
    parameter int unsigned TIMEOUT = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic [7:0] duty,
    output logic       duty_valid,
    output logic       light_on,
    output logic       period_err
);

    localparam int unsigned CW  = 10;
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW1-1:0] PER_HI = CW1'(PERIOD + 1);
    localparam logic [CW1-1:0] PER_LO = CW1'(PERIOD - 1);
    localparam logic [CW1-1:0] TMO    = CW1'(TIMEOUT);
    localparam logic [CW1-1:0] TMO_M1 = CW1'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    // Reset release synchronizer; assertion stays asynchronous
    logic [1:0] rst_sync;
    logic       rst_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_i = rst_sync[1];

    // Input synchronizer and edge detection on s / s_d
    logic sync1;
    logic sync2;
    logic s;
    logic s_d;

`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int unsigned WARM = 4;
    logic h1;
    logic h2;

    // s follows the input only once three consecutive samples agree
    assign s = ((sync2 == h1) && (h1 == h2)) ? sync2 : s_d;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            h1    <= 1'b0;
            h2    <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            h1    <= sync2;
            h2    <= h1;
            s_d   <= s;
        end
    end
`else
    localparam int unsigned WARM = 2;

    assign s = sync2;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            s_d   <= s;
        end
    end
`endif

    logic rise;
    logic fall;

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // After reset the sync flops hold a fake low; a rising edge is only
    // trusted once s has shown a real low, so a partial period is discarded.
    logic [2:0] warm;
    logic       warm_done;
    logic       armed;

    assign warm_done = (warm == 3'(WARM));

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            warm  <= '0;
            armed <= 1'b0;
        end else begin
            if (!warm_done) warm <= warm + 3'd1;
            if (warm_done && !s) armed <= 1'b1;
        end
    end

    // Measurement FSM
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] high_nx;
    logic [CW-1:0] per_cnt;
    logic [CW-1:0] per_nx;
    logic [7:0]    duty_nx;
    logic          light_nx;
    logic          perr_nx;
    logic          valid_nx;
    logic [CW1-1:0] per_w;
    logic [CW1-1:0] high_w;
    logic [7:0]    high_sat;

    assign per_w    = {1'b0, per_cnt};
    assign high_w   = {1'b0, high_cnt};
    assign high_sat = (high_cnt > CW'(255)) ? 8'hFF : high_cnt[7:0];

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            high_cnt   <= '0;
            per_cnt    <= '0;
            duty       <= '0;
            duty_valid <= 1'b0;
            light_on   <= 1'b0;
            period_err <= 1'b0;
        end else begin
            state      <= state_nx;
            high_cnt   <= high_nx;
            per_cnt    <= per_nx;
            duty       <= duty_nx;
            duty_valid <= valid_nx;
            light_on   <= light_nx;
            period_err <= perr_nx;
        end
    end

    // Next state, counters and output values
    always_comb begin
        state_nx = state;
        high_nx  = high_cnt;
        per_nx   = per_cnt;
        duty_nx  = duty;
        light_nx = light_on;
        perr_nx  = period_err;
        valid_nx = 1'b0;

        case (state)
            IDLE: begin
                if (rise && armed) begin
                    state_nx = HIGH;
                    high_nx  = CW'(1);
                    per_nx   = CW'(1);
                end else if (per_w >= TMO_M1) begin
                    // stuck low: re-arm the idle timer and report again later
                    duty_nx  = '0;
                    light_nx = 1'b0;
                    perr_nx  = 1'b1;
                    valid_nx = 1'b1;
                    per_nx   = '0;
                end else begin
                    per_nx = sat_inc(per_cnt);
                end
            end
            HIGH: begin
                per_nx = sat_inc(per_cnt);
                // a falling edge takes priority over an expiring timeout
                if (fall) begin
                    state_nx = LOW;
                end else if (high_w >= TMO) begin
                    duty_nx  = 8'hFF;
                    light_nx = 1'b1;
                    perr_nx  = 1'b1;
                    valid_nx = 1'b1;
                    state_nx = IDLE;
                    high_nx  = '0;
                    per_nx   = '0;
                end else begin
                    high_nx = sat_inc(high_cnt);
                end
            end
            LOW: begin
                if (rise) begin
                    duty_nx  = high_sat;
                    light_nx = (high_sat != 8'd0);
                    perr_nx  = (per_w > PER_HI) || (per_w < PER_LO);
                    valid_nx = 1'b1;
                    state_nx = HIGH;
                    high_nx  = CW'(1);
                    per_nx   = CW'(1);
                end else if (per_w >= TMO) begin
                    duty_nx  = '0;
                    light_nx = 1'b0;
                    perr_nx  = 1'b1;
                    valid_nx = 1'b1;
                    state_nx = IDLE;
                    high_nx  = '0;
                    per_nx   = '0;
                end else begin
                    per_nx = sat_inc(per_cnt);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: a timestamp-based reference model
// pushes expected reports, a negedge monitor pops and compares them.
module tb_pwm_duty_decoder;

    localparam int PERIOD  = 256;
    localparam int TIMEOUT = 512;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       pwm_in = 1'b0;
    logic [7:0] duty;
    logic       duty_valid;
    logic       light_on;
    logic       period_err;

    pwm_duty_decoder #(
        .PERIOD (PERIOD),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .duty_valid(duty_valid),
        .light_on  (light_on),
        .period_err(period_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] duty;
        logic       light;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp = '0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works from timestamps of edges on the sampled input.
    // Sample taken at edge e is visible to the decoder two edges later; the
    // first real sample after reset release is taken at edge 3.
`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int OLDEST = 4;
`else
    localparam int OLDEST = 2;
`endif
    int ecount   = 0;
    bit hist[8];
    int rise_t   = -1;
    int fall_t   = -1;
    int idle_ref = 2;
    bit armed    = 1'b0;
    bit s_prev   = 1'b0;

    task automatic push_exp(input int d, input bit l, input bit p);
        exp_t e;
        e.duty  = 8'(d);
        e.light = l;
        e.perr  = p;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            ecount   = 0;
            for (int k = 0; k < 8; k++) hist[k] = 1'b0;
            rise_t   = -1;
            fall_t   = -1;
            idle_ref = 2;
            armed    = 1'b0;
            s_prev   = 1'b0;
            exp_q.delete();
        end else begin
            bit s_cur;
            bit s_real;
            bit r;
            bit f;
            ecount++;
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = (ecount >= 3) ? pwm_in : 1'b0;
            if (ecount >= 3) begin
`ifdef PWM_DEC_GLITCH_FILTER_EN
                s_cur = ((hist[2] == hist[3]) && (hist[3] == hist[4])) ? hist[2] : s_prev;
`else
                s_cur = hist[2];
`endif
                s_real = (ecount - OLDEST) >= 3;
                r = s_cur && !s_prev;
                f = !s_cur && s_prev;
                if (rise_t < 0) begin
                    if (r && armed) begin
                        rise_t = ecount;
                        fall_t = -1;
                    end else if (ecount - idle_ref >= TIMEOUT) begin
                        push_exp(0, 1'b0, 1'b1);
                        idle_ref = ecount;
                    end
                end else if (fall_t < 0) begin
                    if (f) begin
                        fall_t = ecount;
                    end else if (ecount - rise_t >= TIMEOUT) begin
                        push_exp(255, 1'b1, 1'b1);
                        rise_t   = -1;
                        idle_ref = ecount;
                    end
                end else begin
                    if (r) begin
                        int h;
                        int p;
                        h = fall_t - rise_t;
                        p = ecount - rise_t;
                        push_exp((h > 255) ? 255 : h, h != 0,
                                 (p > PERIOD + 1) || (p < PERIOD - 1));
                        rise_t = ecount;
                        fall_t = -1;
                    end else if (ecount - rise_t >= TIMEOUT) begin
                        push_exp(0, 1'b0, 1'b1);
                        rise_t   = -1;
                        idle_ref = ecount;
                    end
                end
                if (s_real && !s_cur) armed = 1'b1;
                s_prev = s_cur;
            end
        end
    end

    // Monitor: every negedge compares presence, value or hold of the outputs
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", 32'({duty, duty_valid, light_on, period_err}), 32'd0);
            last_exp = '0;
        end else begin
            check("valid_presence", 32'(duty_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (duty_valid)
                    check("decoded_value", 32'({duty, light_on, period_err}), 32'(e));
                last_exp = e;
            end else if (!duty_valid) begin
                check("hold", 32'({duty, light_on, period_err}), 32'(last_exp));
            end
        end
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            pwm_in = v;
        end
    endtask

    task automatic seg(input int h, input int l, input int reps);
        repeat (reps) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_duty"}, 32'(duty), 32'd0);
        check({tag, "_valid"}, 32'(duty_valid), 32'd0);
        check({tag, "_light"}, 32'(light_on), 32'd0);
        check({tag, "_perr"}, 32'(period_err), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_zero_outputs("por");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // held low from reset: periodic stuck-low reports
        drive(1'b0, 2000);
        // nominal 64/192
        seg(64, 192, 5);
        // 255 high / 1 low, then stuck high
        seg(255, 1, 4);
        drive(1'b1, 1300);
        drive(1'b0, 100);
        // off-period and near-period cases
        seg(10, 190, 3);
        seg(10, 247, 3);
        seg(10, 245, 2);
        // short glitch inside a long high pulse
        drive(1'b1, 48);
        drive(1'b0, 2);
        drive(1'b1, 50);
        drive(1'b0, 156);
        seg(100, 156, 2);

        // reset in the middle of a high phase
        drive(1'b1, 30);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("mid_reset");
        drive(1'b1, 3);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive(1'b1, 40);
        drive(1'b0, 150);
        seg(64, 192, 3);

        // randomized segments, occasionally long enough to time out
        for (int i = 0; i < 30; i++) begin
            int h;
            int l;
            h = $urandom_range(1, 300);
            l = $urandom_range(1, 300);
            if ($urandom_range(0, 5) == 0) h = $urandom_range(1, 3);
            if ($urandom_range(0, 5) == 0) l = $urandom_range(1, 3);
            if ($urandom_range(0, 9) == 0) l = $urandom_range(500, 700);
            if ($urandom_range(0, 9) == 0) h = $urandom_range(500, 600);
            seg(h, l, 1);
        end

        drive(1'b0, 20);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
